// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline constants for the ID-stage hazard logic: opcodes, register width
// and the stall FSM state encoding.
package hazard_stall_unit_pkg;

    localparam int REG_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic {
        HZ_IDLE  = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_stall_unit_decode.sv
// Combinational operand-usage decode of the IF/ID instruction; shared with the
// forwarding unit so both agree on which fields are real sources.
module hazard_decode
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W = hazard_stall_unit_pkg::REG_W
) (
    input  logic [31:0]      instr,
    output logic             uses_rs,
    output logic             uses_rt,
    output logic             id_branch,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_bits;

    always_comb begin
        op    = instr[31:26];
        funct = instr[5:0];
        rs    = REG_W'(instr[25:21]);
        rt    = REG_W'(instr[20:16]);

        uses_rs   = !(op == OP_J || op == OP_JAL || op == OP_LUI);
        // rt is a destination for loads and immediates, so only these read it
        uses_rt   = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
        id_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_RTYPE && funct == FUNCT_JR);
    end

    assign unused_bits = ^instr[15:6];

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector: stalls PC/IF/ID and bubbles ID/EX on load-use and
// branch-operand hazards, flushes IF/ID on taken branches. HAZARD_STATS_EN adds a stall counter.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W   = hazard_stall_unit_pkg::REG_W,
    parameter int STATS_W = 32
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic [31:0]        Instruction_IN,
    input  logic               IDEX_MemRead,
    input  logic               IDEX_RegWrite,
    input  logic [REG_W-1:0]   IDEX_RegD,
    input  logic               EXMEM_MemRead,
    input  logic [REG_W-1:0]   EXMEM_RegD,
    input  logic               Branch_Taken,
    output logic               PC_Write,
    output logic               IFID_Write,
    output logic               IDEX_Bubble,
    output logic               IFID_Flush,
    output logic [STATS_W-1:0] Stall_Cycles
);

    logic             uses_rs, uses_rt, id_branch;
    logic [REG_W-1:0] rs, rt;

    hazard_decode #(.REG_W(REG_W)) u_decode (
        .instr     (Instruction_IN),
        .uses_rs   (uses_rs),
        .uses_rt   (uses_rt),
        .id_branch (id_branch),
        .rs        (rs),
        .rt        (rt)
    );

    logic      idex_match, exmem_match;
    logic      h1_load_use, h2_br_alu, h3_br_load_ex, h4_br_load_mem, hazard;
    logic      stall;
    hz_state_e state_q, state_d;
    logic      rem_q, rem_d;

    always_comb begin
        idex_match  = (IDEX_RegD != '0) &&
                      ((uses_rs && rs == IDEX_RegD) || (uses_rt && rt == IDEX_RegD));
        exmem_match = (EXMEM_RegD != '0) &&
                      ((uses_rs && rs == EXMEM_RegD) || (uses_rt && rt == EXMEM_RegD));

        h1_load_use    = IDEX_MemRead && idex_match;
        h2_br_alu      = id_branch && IDEX_RegWrite && !IDEX_MemRead && idex_match;
        h3_br_load_ex  = id_branch && IDEX_MemRead && idex_match;
        h4_br_load_mem = id_branch && EXMEM_MemRead && exmem_match;
        hazard         = h1_load_use || h2_br_alu || h3_br_load_ex || h4_br_load_mem;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stall   = 1'b0;
        unique case (state_q)
            HZ_IDLE: begin
                stall = hazard;
                // Single-cycle hazards are cleared by the bubble; only the EX-stage
                // load feeding a branch needs a second cycle.
                if (h3_br_load_ex) begin
                    state_d = HZ_STALL;
                    rem_d   = 1'b1;
                end
            end
            HZ_STALL: begin
                stall = 1'b1;
                rem_d = rem_q - 1'b1;
                if (rem_q == 1'b1) state_d = HZ_IDLE;
            end
            default: begin
                state_d = HZ_IDLE;
                rem_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= HZ_IDLE;
            rem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Reset gating keeps an undefined instruction word from reaching the outputs.
    always_comb begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
        IFID_Flush  = 1'b0;
        if (RESET_N) begin
            PC_Write    = !stall;
            IFID_Write  = !stall;
            IDEX_Bubble = stall;
            IFID_Flush  = Branch_Taken && !stall;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STATS_W-1:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) stall_cycles_q <= '0;
        else          stall_cycles_q <= stall_cycles_d;
    end

    assign Stall_Cycles = stall_cycles_q;
`else
    assign Stall_Cycles = {STATS_W{1'b0}};
`endif

endmodule
